// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline register: drives the data-cache request from EX/MEM,
// stalls upstream until dhit, and captures writeback state for WB. Halt is sticky until RST.
module mem_wb_stage #(
  parameter int WAITCNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 enable_MEM_WB,
  input  logic                 flush_MEM_WB,
  input  logic                 WEN_EX_MEM,
  input  logic                 dmemREN_EX_MEM,
  input  logic                 dmemWEN_EX_MEM,
  input  logic                 halt_EX_MEM,
  input  logic [1:0]           reg_dest_EX_MEM,
  input  logic [4:0]           Rt_EX_MEM,
  input  logic [4:0]           Rd_EX_MEM,
  input  logic [31:0]          result_EX_MEM,
  input  logic [31:0]          dmemstore_EX_MEM,
  input  logic [31:0]          imemaddr_EX_MEM,
  input  logic                 dhit,
  input  logic [31:0]          dmemload,
  output logic                 dmemREN,
  output logic                 dmemWEN,
  output logic [31:0]          dmemaddr,
  output logic [31:0]          dmemstore,
  output logic                 stall_MEM,
  output logic                 WEN_MEM_WB,
  output logic [4:0]           wsel_MEM_WB,
  output logic [31:0]          wdat_MEM_WB,
  output logic                 halt_MEM_WB,
  output logic [31:0]          imemaddr_MEM_WB,
  output logic [WAITCNT_W-1:0] wait_cycles
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, HALT} state_t;

  typedef struct packed {
    logic        wen;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic        halt;
    logic [31:0] pc;
  } mem_wb_t;

  state_t      state;
  mem_wb_t     mwb, nxt;
  logic [31:0] done_data;
  logic        memop, is_load, req, capture, bubble;

  // Store wins when both read and write are flagged.
  assign memop   = dmemREN_EX_MEM | dmemWEN_EX_MEM;
  assign is_load = dmemREN_EX_MEM & ~dmemWEN_EX_MEM;

  assign req       = ~RST & memop & (state == IDLE || state == WAIT);
  assign dmemREN   = req & is_load;
  assign dmemWEN   = req & dmemWEN_EX_MEM;
  assign dmemaddr  = result_EX_MEM;
  assign dmemstore = dmemstore_EX_MEM;

  assign stall_MEM = ~RST & (
      (memop & ~dhit & state != HALT & state != DONE)
    | (state == DONE & ~enable_MEM_WB)
    | (state == IDLE & memop & dhit & ~enable_MEM_WB));

  assign bubble  = state != HALT & (flush_MEM_WB | (stall_MEM & enable_MEM_WB));
  assign capture = state != HALT & ~flush_MEM_WB & enable_MEM_WB & ~stall_MEM;

  always_comb begin
    nxt      = '0;
    nxt.wen  = WEN_EX_MEM & (reg_dest_EX_MEM != 2'd3);
    case (reg_dest_EX_MEM)
      2'd0:    nxt.wsel = Rt_EX_MEM;
      2'd1:    nxt.wsel = Rd_EX_MEM;
      2'd2:    nxt.wsel = 5'd31;
      default: nxt.wsel = 5'd0;
    endcase
    nxt.wdat = is_load ? ((state == DONE) ? done_data : dmemload) : result_EX_MEM;
    nxt.halt = halt_EX_MEM;
    nxt.pc   = imemaddr_EX_MEM;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      mwb         <= '0;
      done_data   <= '0;
      wait_cycles <= '0;
    end else begin
      if (stall_MEM && wait_cycles != '1)
        wait_cycles <= wait_cycles + 1'b1;

      if (bubble)       mwb <= '0;
      else if (capture) mwb <= nxt;

      case (state)
        IDLE: if (memop) begin
          if (!dhit) state <= WAIT;
          else if (!enable_MEM_WB) begin
            done_data <= dmemload;
            state     <= DONE;
          end
        end
        WAIT: if (dhit) begin
          // Hold the load data so the cache is not accessed a second time.
          if (enable_MEM_WB) state <= IDLE;
          else begin
            done_data <= dmemload;
            state     <= DONE;
          end
        end
        DONE: if (enable_MEM_WB) state <= IDLE;
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase

      if (capture && halt_EX_MEM) state <= HALT;
    end
  end

  assign WEN_MEM_WB      = mwb.wen;
  assign wsel_MEM_WB     = mwb.wsel;
  assign wdat_MEM_WB     = mwb.wdat;
  assign halt_MEM_WB     = mwb.halt;
  assign imemaddr_MEM_WB = mwb.pc;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU pass-through, waited load, zero-wait store,
// DONE hold, flush/wsel corner codes, sticky halt, and reset mid-access with saturation.
module tb_mem_wb_stage;
  logic        CLK = 0, RST;
  logic        enable_MEM_WB, flush_MEM_WB, WEN_EX_MEM, dmemREN_EX_MEM, dmemWEN_EX_MEM, halt_EX_MEM;
  logic [1:0]  reg_dest_EX_MEM;
  logic [4:0]  Rt_EX_MEM, Rd_EX_MEM;
  logic [31:0] result_EX_MEM, dmemstore_EX_MEM, imemaddr_EX_MEM, dmemload;
  logic        dhit, dmemREN, dmemWEN, stall_MEM, WEN_MEM_WB, halt_MEM_WB;
  logic [31:0] dmemaddr, dmemstore, wdat_MEM_WB, imemaddr_MEM_WB;
  logic [4:0]  wsel_MEM_WB;
  logic [3:0]  wait_cycles;

  int n_cmp = 0, n_bad = 0;

  mem_wb_stage #(.WAITCNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .enable_MEM_WB(enable_MEM_WB), .flush_MEM_WB(flush_MEM_WB),
    .WEN_EX_MEM(WEN_EX_MEM), .dmemREN_EX_MEM(dmemREN_EX_MEM), .dmemWEN_EX_MEM(dmemWEN_EX_MEM),
    .halt_EX_MEM(halt_EX_MEM), .reg_dest_EX_MEM(reg_dest_EX_MEM), .Rt_EX_MEM(Rt_EX_MEM),
    .Rd_EX_MEM(Rd_EX_MEM), .result_EX_MEM(result_EX_MEM), .dmemstore_EX_MEM(dmemstore_EX_MEM),
    .imemaddr_EX_MEM(imemaddr_EX_MEM), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .stall_MEM(stall_MEM), .WEN_MEM_WB(WEN_MEM_WB), .wsel_MEM_WB(wsel_MEM_WB),
    .wdat_MEM_WB(wdat_MEM_WB), .halt_MEM_WB(halt_MEM_WB), .imemaddr_MEM_WB(imemaddr_MEM_WB),
    .wait_cycles(wait_cycles)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic clr;
    enable_MEM_WB = 1; flush_MEM_WB = 0; WEN_EX_MEM = 0; dmemREN_EX_MEM = 0;
    dmemWEN_EX_MEM = 0; halt_EX_MEM = 0; reg_dest_EX_MEM = 0; Rt_EX_MEM = 0; Rd_EX_MEM = 0;
    result_EX_MEM = 0; dmemstore_EX_MEM = 0; imemaddr_EX_MEM = 0; dhit = 0; dmemload = 0;
  endtask

  initial begin
    clr(); RST = 1;
    tick(); tick();
    RST = 0; #1;
    chk("rst_wen", WEN_MEM_WB, 0);   chk("rst_wsel", wsel_MEM_WB, 0);
    chk("rst_wdat", wdat_MEM_WB, 0); chk("rst_halt", halt_MEM_WB, 0);
    chk("rst_pc", imemaddr_MEM_WB, 0); chk("rst_wait", wait_cycles, 0);
    chk("rst_stall", stall_MEM, 0);  chk("rst_ren", dmemREN, 0);

    // ALU op passes straight through
    WEN_EX_MEM = 1; reg_dest_EX_MEM = 1; Rd_EX_MEM = 5; result_EX_MEM = 32'h10;
    imemaddr_EX_MEM = 32'h100; #1;
    chk("alu_ren", dmemREN, 0); chk("alu_wen_req", dmemWEN, 0); chk("alu_stall", stall_MEM, 0);
    tick();
    chk("alu_wen", WEN_MEM_WB, 1); chk("alu_wsel", wsel_MEM_WB, 5);
    chk("alu_wdat", wdat_MEM_WB, 32'h10); chk("alu_pc", imemaddr_MEM_WB, 32'h100);

    // Load with three wait cycles
    clr(); dmemREN_EX_MEM = 1; WEN_EX_MEM = 1; Rt_EX_MEM = 7; result_EX_MEM = 32'h40;
    imemaddr_EX_MEM = 32'h104; #1;
    chk("ld_ren0", dmemREN, 1); chk("ld_addr", dmemaddr, 32'h40); chk("ld_stall0", stall_MEM, 1);
    tick();
    chk("ld_bubble", WEN_MEM_WB, 0); chk("ld_ren1", dmemREN, 1); chk("ld_stall1", stall_MEM, 1);
    tick(); tick();
    chk("ld_stall3", stall_MEM, 1);
    dhit = 1; dmemload = 32'hDEADBEEF; #1;
    chk("ld_hit_stall", stall_MEM, 0); chk("ld_hit_ren", dmemREN, 1);
    tick();
    chk("ld_wen", WEN_MEM_WB, 1); chk("ld_wsel", wsel_MEM_WB, 7);
    chk("ld_wdat", wdat_MEM_WB, 32'hDEADBEEF); chk("ld_wait", wait_cycles, 3);

    // Store completing in the same cycle
    clr(); dmemWEN_EX_MEM = 1; result_EX_MEM = 32'h80; dmemstore_EX_MEM = 32'h1234; dhit = 1; #1;
    chk("st_wen_req", dmemWEN, 1); chk("st_ren_req", dmemREN, 0);
    chk("st_data", dmemstore, 32'h1234); chk("st_addr", dmemaddr, 32'h80); chk("st_stall", stall_MEM, 0);
    tick();
    clr(); #1;
    chk("st_wen_drop", dmemWEN, 0); chk("st_wb_wen", WEN_MEM_WB, 0); chk("st_wait", wait_cycles, 3);

    // Load hits while MEM/WB is blocked: DONE holds data without re-accessing
    dmemREN_EX_MEM = 1; WEN_EX_MEM = 1; reg_dest_EX_MEM = 1; Rd_EX_MEM = 9; result_EX_MEM = 32'h44;
    dhit = 1; dmemload = 32'hCAFEF00D; enable_MEM_WB = 0; #1;
    chk("dn_stall0", stall_MEM, 1); chk("dn_ren0", dmemREN, 1);
    tick();
    dhit = 0; dmemload = 32'h0BAD0BAD; #1;
    chk("dn_ren1", dmemREN, 0); chk("dn_stall1", stall_MEM, 1); chk("dn_hold", WEN_MEM_WB, 0);
    tick();
    chk("dn_ren2", dmemREN, 0); chk("dn_stall2", stall_MEM, 1);
    enable_MEM_WB = 1; #1;
    chk("dn_release", stall_MEM, 0);
    tick();
    chk("dn_wdat", wdat_MEM_WB, 32'hCAFEF00D); chk("dn_wsel", wsel_MEM_WB, 9);
    chk("dn_wen", WEN_MEM_WB, 1); chk("dn_wait", wait_cycles, 5);
    clr(); #1;
    chk("dn_idle_ren", dmemREN, 0);

    // Flush, R31 destination, invalid reg_dest code, hold on enable=0
    WEN_EX_MEM = 1; reg_dest_EX_MEM = 1; Rd_EX_MEM = 3; result_EX_MEM = 32'h55;
    imemaddr_EX_MEM = 32'h300; flush_MEM_WB = 1;
    tick();
    chk("fl_wen", WEN_MEM_WB, 0); chk("fl_wdat", wdat_MEM_WB, 0); chk("fl_pc", imemaddr_MEM_WB, 0);
    flush_MEM_WB = 0; reg_dest_EX_MEM = 2; result_EX_MEM = 32'h66;
    tick();
    chk("r31_wsel", wsel_MEM_WB, 31); chk("r31_wen", WEN_MEM_WB, 1); chk("r31_wdat", wdat_MEM_WB, 32'h66);
    reg_dest_EX_MEM = 3; Rt_EX_MEM = 4; Rd_EX_MEM = 5; result_EX_MEM = 32'h77;
    tick();
    chk("rd3_wen", WEN_MEM_WB, 0); chk("rd3_wsel", wsel_MEM_WB, 0); chk("rd3_wdat", wdat_MEM_WB, 32'h77);
    enable_MEM_WB = 0; reg_dest_EX_MEM = 1; result_EX_MEM = 32'h88;
    tick();
    chk("hold_wdat", wdat_MEM_WB, 32'h77);

    // Sticky halt freezes MEM/WB and blocks requests
    clr(); halt_EX_MEM = 1; imemaddr_EX_MEM = 32'h200;
    tick();
    chk("hlt_set", halt_MEM_WB, 1); chk("hlt_pc", imemaddr_MEM_WB, 32'h200);
    clr(); dmemREN_EX_MEM = 1; WEN_EX_MEM = 1; result_EX_MEM = 32'h40; imemaddr_EX_MEM = 32'h204; #1;
    chk("hlt_ren", dmemREN, 0); chk("hlt_stall", stall_MEM, 0);
    flush_MEM_WB = 1;
    tick(); tick();
    chk("hlt_sticky", halt_MEM_WB, 1); chk("hlt_frozen", imemaddr_MEM_WB, 32'h200);
    clr(); RST = 1;
    tick();
    RST = 0; #1;
    chk("hlt_rst", halt_MEM_WB, 0); chk("hlt_rst_wait", wait_cycles, 0);

    // Long wait saturates the counter, then reset mid-access
    dmemREN_EX_MEM = 1; WEN_EX_MEM = 1; result_EX_MEM = 32'h90; imemaddr_EX_MEM = 32'h400;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_wait", wait_cycles, 15); chk("sat_ren", dmemREN, 1); chk("sat_stall", stall_MEM, 1);
    tick();
    chk("sat_hold", wait_cycles, 15);
    RST = 1; #1;
    chk("rw_ren_drop", dmemREN, 0); chk("rw_stall_drop", stall_MEM, 0);
    tick();
    RST = 0; clr(); #1;
    chk("rw_ren", dmemREN, 0); chk("rw_wait", wait_cycles, 0); chk("rw_wen", WEN_MEM_WB, 0);
    chk("rw_wdat", wdat_MEM_WB, 0); chk("rw_pc", imemaddr_MEM_WB, 0); chk("rw_stall", stall_MEM, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
